wta_reg_bank: RTL and testbench

//   Write-side counterpart of the WTA read mux: accepts a (dest-select, op, data) request from the

---
 rtl/wta_pkg.sv | 30 +++
 rtl/wta_req_buf.sv | 33 +++
 rtl/wta_reg_bank.sv | 115 +++++++++++
 tb/tb_wta_reg_bank.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/wta_pkg.sv
// Shared WTA definitions: bus widths, 4-bit register codes (common with the read mux) and the
// 2-bit write-op encoding.
package wta_pkg;
  localparam int DATA_W   = 16;
  localparam int NUM_REGS = 15;

  localparam logic [3:0] REG_N       = 4'd0;
  localparam logic [3:0] REG_M       = 4'd1;
  localparam logic [3:0] REG_P       = 4'd2;
  localparam logic [3:0] REG_R1      = 4'd3;
  localparam logic [3:0] REG_ROW     = 4'd4;
  localparam logic [3:0] REG_COL     = 4'd5;
  localparam logic [3:0] REG_CURR    = 4'd6;
  localparam logic [3:0] REG_SUM     = 4'd7;
  localparam logic [3:0] REG_STA     = 4'd8;
  localparam logic [3:0] REG_STB     = 4'd9;
  localparam logic [3:0] REG_STC     = 4'd10;
  localparam logic [3:0] REG_A       = 4'd11;
  localparam logic [3:0] REG_B       = 4'd12;
  localparam logic [3:0] REG_R       = 4'd13;
  localparam logic [3:0] REG_CORE_ID = 4'd14;
  localparam logic [3:0] REG_NONE    = 4'd15;

  typedef enum logic [1:0] {
    OP_LOAD = 2'b00,
    OP_INC  = 2'b01,
    OP_CLR  = 2'b10,
    OP_ACC  = 2'b11
  } op_e;
endpackage

// File: rtl/wta_req_buf.sv
// One-entry request buffer; entry is visible the cycle after accept.
// Backpressure: in_rdy drops only while full and hold is high; commit and refill may share an edge.
module wta_req_buf #(
  parameter int W = 22
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         in_vld,
  output logic         in_rdy,
  input  logic [W-1:0] in_dat,
  input  logic         hold,
  output logic         out_vld,
  output logic [W-1:0] out_dat
);
  logic         full_q;
  logic [W-1:0] dat_q;

  assign in_rdy  = !full_q || !hold;
  assign out_vld = full_q;
  assign out_dat = dat_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      full_q <= 1'b0;
      dat_q  <= '0;
    end else if (in_vld && in_rdy) begin
      full_q <= 1'b1;
      dat_q  <= in_dat;
    end else if (full_q && !hold) begin
      full_q <= 1'b0;
    end
  end
endmodule

// File: rtl/wta_reg_bank.sv
// WTA write side: buffered (sel, op, data) requests commit into 15 registers, 1 cycle after accept.
// Backpressure: io_in_ready low only while a buffered request is stalled by io_hold.
module wta_reg_bank #(
  parameter int          DATA_W   = wta_pkg::DATA_W,
  parameter int          NUM_REGS = wta_pkg::NUM_REGS,
  parameter int unsigned CORE_ID  = 0
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       io_in_valid,
  output logic                       io_in_ready,
  input  logic [3:0]                 io_in_sel,
  input  logic [1:0]                 io_in_op,
  input  logic [DATA_W-1:0]          io_in_data,
  input  logic                       io_hold,
  output logic [NUM_REGS*DATA_W-1:0] io_regs,
  output logic                       io_wr_done,
  output logic                       io_wrap,
  output logic                       io_err
);
  import wta_pkg::*;

  typedef struct packed {
    logic [3:0]        sel;
    op_e               op;
    logic [DATA_W-1:0] dat;
  } req_t;

  req_t                in_req;
  req_t                buf_req;
  logic                buf_vld;
  logic                commit;
  logic                legal;
  logic                carry;
  logic [DATA_W-1:0]   cur;
  logic [DATA_W-1:0]   result;
  logic [DATA_W:0]     sum;
  logic [NUM_REGS-1:0] wr_onehot;
  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic                wr_done_q;
  logic                wrap_q;
  logic                err_q;

  assign in_req = '{sel: io_in_sel, op: op_e'(io_in_op), dat: io_in_data};

  wta_req_buf #(.W($bits(req_t))) u_req_buf (
    .clock   (clock),
    .reset   (reset),
    .in_vld  (io_in_valid),
    .in_rdy  (io_in_ready),
    .in_dat  (in_req),
    .hold    (io_hold),
    .out_vld (buf_vld),
    .out_dat (buf_req)
  );

  assign commit = buf_vld && !io_hold;
  // The top code of the array is the read-only CoreID; it and the "none" code are never written.
  assign legal  = int'(buf_req.sel) < NUM_REGS - 1;

  always_comb begin
    cur = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (buf_req.sel == 4'(k)) cur = regs_q[k];
    end
  end

  assign sum = {1'b0, cur} + {1'b0, (buf_req.op == OP_INC) ? DATA_W'(1) : buf_req.dat};

  always_comb begin
    result = '0;
    unique case (buf_req.op)
      OP_LOAD: result = buf_req.dat;
      OP_INC:  result = sum[DATA_W-1:0];
      OP_CLR:  result = '0;
      OP_ACC:  result = sum[DATA_W-1:0];
      default: result = '0;
    endcase
  end

  assign carry     = legal && (buf_req.op == OP_INC || buf_req.op == OP_ACC) && sum[DATA_W];
  assign wr_onehot = (commit && legal) ? (NUM_REGS'(1) << buf_req.sel) : '0;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < NUM_REGS; k++) begin
        regs_q[k] <= (k == NUM_REGS - 1) ? DATA_W'(CORE_ID) : '0;
      end
    end else begin
      for (int k = 0; k < NUM_REGS; k++) begin
        if (wr_onehot[k]) regs_q[k] <= result;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_done_q <= 1'b0;
      wrap_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      wr_done_q <= commit;
      wrap_q    <= commit && carry;
      err_q     <= err_q || (commit && !legal);
    end
  end

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_regs_out
    assign io_regs[k*DATA_W +: DATA_W] = regs_q[k];
  end

  assign io_wr_done = wr_done_q;
  assign io_wrap    = wrap_q;
  assign io_err     = err_q;
endmodule

// File: tb/tb_wta_reg_bank.sv
// Directed + random bench for wta_reg_bank against an arithmetic reference model.
module tb_wta_reg_bank;
  localparam int DW  = 16;
  localparam int NR  = 15;
  localparam int CID = 'h5A;

  logic           clock = 1'b0;
  logic           reset = 1'b0;
  logic           io_in_valid;
  logic           io_in_ready;
  logic [3:0]     io_in_sel;
  logic [1:0]     io_in_op;
  logic [DW-1:0]  io_in_data;
  logic           io_hold;
  logic [NR*DW-1:0] io_regs;
  logic           io_wr_done;
  logic           io_wrap;
  logic           io_err;

  wta_reg_bank #(.DATA_W(DW), .NUM_REGS(NR), .CORE_ID(CID)) dut (
    .clock       (clock),
    .reset       (reset),
    .io_in_valid (io_in_valid),
    .io_in_ready (io_in_ready),
    .io_in_sel   (io_in_sel),
    .io_in_op    (io_in_op),
    .io_in_data  (io_in_data),
    .io_hold     (io_hold),
    .io_regs     (io_regs),
    .io_wr_done  (io_wr_done),
    .io_wrap     (io_wrap),
    .io_err      (io_err)
  );

  always #5 clock = ~clock;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: register values, one pending request, expected pulses.
  int model [NR];
  bit pend;
  int p_sel, p_op, p_data;
  bit exp_done, exp_wrap, exp_err;

  localparam int LOAD = 0, INC = 1, CLR = 2, ACC = 3;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    assert (act === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] word(input int k);
    return io_regs[k*DW +: DW];
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NR; k++) model[k] = 0;
    model[NR-1] = CID;
    pend = 0;
    exp_done = 0;
    exp_wrap = 0;
    exp_err = 0;
  endtask

  task automatic model_commit();
    int s;
    exp_done = 1;
    if (p_sel >= NR - 1) begin
      exp_err = 1;
    end else begin
      if (p_op == LOAD)     s = p_data;
      else if (p_op == CLR) s = 0;
      else if (p_op == INC) s = model[p_sel] + 1;
      else                  s = model[p_sel] + p_data;
      exp_wrap = (p_op == INC || p_op == ACC) && (s > 'hFFFF);
      model[p_sel] = s % 65536;
    end
  endtask

  task automatic check_all(input string tag);
    for (int k = 0; k < NR; k++)
      chk($sformatf("%s reg%0d", tag, k), word(k), model[k]);
    chk({tag, " wr_done"}, io_wr_done, exp_done);
    chk({tag, " wrap"}, io_wrap, exp_wrap);
    chk({tag, " err"}, io_err, exp_err);
    chk({tag, " ready"}, io_in_ready, (!pend || !io_hold));
  endtask

  task automatic cycle(input string tag);
    bit acc;
    @(posedge clock);
    acc = io_in_valid && (!pend || !io_hold);
    exp_done = 0;
    exp_wrap = 0;
    if (pend && !io_hold) begin
      model_commit();
      pend = 0;
    end
    if (acc) begin
      pend   = 1;
      p_sel  = io_in_sel;
      p_op   = io_in_op;
      p_data = io_in_data;
    end
    #1;
    check_all(tag);
  endtask

  task automatic req(input bit v, input int sel, input int op, input int data);
    io_in_valid = v;
    io_in_sel   = 4'(sel);
    io_in_op    = 2'(op);
    io_in_data  = DW'(data);
  endtask

  int sweep [14] = '{31, 22, 43, 24, 25, 16, 27, 38, 439, 10, 11, 12, 13, 14};

  initial begin
    req(0, 0, LOAD, 0);
    io_hold = 0;
    model_reset();

    // Reset state while held low, then release away from the edge.
    #12;
    check_all("reset");
    chk("reset coreid", word(NR-1), CID);
    #5 reset = 1;
    cycle("idle");

    // Load sweep on consecutive cycles.
    for (int k = 0; k < 14; k++) begin
      req(1, k, LOAD, sweep[k]);
      cycle("sweep");
    end
    req(0, 0, LOAD, 0);
    cycle("sweep end");
    chk("sweep STA", word(8), 439);
    chk("sweep R", word(13), 14);

    // INC wraps ROW, back-to-back on same register.
    req(1, 4, LOAD, 'hFFFF);
    cycle("row load");
    req(1, 4, INC, 0);
    cycle("row inc");
    req(0, 0, LOAD, 0);
    cycle("row wrap");
    chk("row value", word(4), 0);
    chk("row wrap pulse", io_wrap, 1);

    // ACC without wrap, then CLR.
    req(1, 7, LOAD, 38);
    cycle("sum load");
    req(1, 7, ACC, 439);
    cycle("sum acc");
    req(1, 7, CLR, 1234);
    cycle("sum acc done");
    chk("sum 477", word(7), 477);
    chk("sum nowrap", io_wrap, 0);
    req(0, 0, LOAD, 0);
    cycle("sum clr");
    chk("sum clr", word(7), 0);

    // Stall: clear A, then LOAD A=12 held for 3 cycles with a second request waiting.
    req(1, 11, CLR, 0);
    cycle("a clr");
    req(0, 0, LOAD, 0);
    cycle("a clr done");
    io_hold = 1;
    req(1, 11, LOAD, 12);
    cycle("stall accept");
    req(1, 12, LOAD, 77);
    repeat (3) begin
      cycle("stall");
      chk("stall ready", io_in_ready, 0);
      chk("stall A", word(11), 0);
    end
    io_hold = 0;
    cycle("stall release");
    chk("release A", word(11), 12);
    req(0, 0, LOAD, 0);
    cycle("stall second");
    chk("release B", word(12), 77);

    // Illegal destinations.
    req(1, 14, LOAD, 99);
    cycle("ill14");
    req(0, 0, LOAD, 0);
    cycle("ill14 done");
    chk("ill coreid", word(14), CID);
    chk("ill done", io_wr_done, 1);
    chk("ill err", io_err, 1);
    req(1, 15, LOAD, 5);
    cycle("ill15");
    req(0, 0, LOAD, 0);
    cycle("ill15 done");
    cycle("ill sticky");
    chk("err sticky", io_err, 1);

    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      req($urandom_range(0, 3) != 0, $urandom_range(0, 15), $urandom_range(0, 3),
          ($urandom_range(0, 3) == 0) ? 'hFFFF : int'($urandom_range(0, 'hFFFF)));
      io_hold = ($urandom_range(0, 3) == 0);
      cycle("rand");
    end
    io_hold = 0;
    req(0, 0, LOAD, 0);
    cycle("flush");
    cycle("flush");

    // Reset with a stalled request in the buffer.
    io_hold = 1;
    req(1, 12, LOAD, 13);
    cycle("midop accept");
    req(0, 0, LOAD, 0);
    cycle("midop held");
    #3 reset = 0;
    #1;
    model_reset();
    check_all("midop reset");
    chk("midop B", word(12), 0);
    chk("midop coreid", word(14), CID);
    @(posedge clock);
    #3 reset = 1;
    cycle("post reset");
    chk("post ready", io_in_ready, 1);
    io_hold = 0;
    cycle("post release");
    chk("dropped req", io_wr_done, 0);
    chk("dropped B", word(12), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
